line_pingpong_buffer: RTL and testbench

Parametrised double-buffered line store between a layer or sprite renderer and the composer. The renderer fills one buffer while the composer reads the other. The roles swap under an explicit request/acknowledge handshake, so the renderer does not have to drive a buffer-select line. Every pixel the composer reads is cleared back to `CLEAR_VALUE` behind the read, and the whole store is swept clear after reset, so the renderer never has to erase a line before drawing it.

---
 rtl/line_pingpong_if.sv | 27 ++
 rtl/line_pingpong_buffer.sv | 143 ++++++++++++++
 tb/tb_line_pingpong_buffer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_pingpong_if.sv
// Renderer/composer-side signal bundle for the ping-pong line store.
// The slave modport is the buffer; the master modport is its user.
interface line_pingpong_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 10
);
  logic                  ready;
  logic                  render_sel;
  logic                  swap_req;
  logic                  swap_done;
  logic [IDX_WIDTH-1:0]  wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic [IDX_WIDTH-1:0]  rd_idx;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    input  ready, render_sel, swap_done, rd_data,
    output swap_req, wr_idx, wr_data, wr_en, rd_idx, rd_en
  );

  modport slave (
    output ready, render_sel, swap_done, rd_data,
    input  swap_req, wr_idx, wr_data, wr_en, rd_idx, rd_en
  );
endinterface

// File: rtl/line_pingpong_buffer.sv
// Double-buffered line store: the renderer fills one buffer while the composer
// reads the other and clears each pixel behind the read; roles swap on request.
module line_pingpong_buffer #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    LINE_PIXELS = 640,
  parameter int                    IDX_WIDTH   = 10,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  line_pingpong_if.slave bus
);

  localparam logic [0:0]           ST_INIT  = 1'b0;
  localparam logic [0:0]           ST_RUN   = 1'b1;
  localparam logic [IDX_WIDTH:0]   LINE_END = (IDX_WIDTH+1)'(LINE_PIXELS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(LINE_PIXELS - 1);

  logic [DATA_WIDTH-1:0] mem0 [LINE_PIXELS];
  logic [DATA_WIDTH-1:0] mem1 [LINE_PIXELS];

  logic [0:0]            state_q, state_d;
  logic [IDX_WIDTH-1:0]  sweep_q, sweep_d;
  logic                  ready_q, ready_d;
  logic                  render_sel_q, render_sel_d;
  logic                  swap_done_q, swap_done_d;
  logic                  swap_pend_q, swap_pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [IDX_WIDTH-1:0]  pend_idx_q, pend_idx_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                  run;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  rd_hit;
  logic                  erase;
  logic                  swap_fire;
  logic [1:0]            we;
  logic [IDX_WIDTH-1:0]  wa [2];
  logic [DATA_WIDTH-1:0] wd [2];
  logic [DATA_WIDTH-1:0] rd_word;

  assign run         = (state_q == ST_RUN);
  assign wr_in_range = ({1'b0, bus.wr_idx} < LINE_END);
  assign rd_in_range = ({1'b0, bus.rd_idx} < LINE_END);
  assign rd_hit      = run && bus.rd_en && rd_in_range;
  // A swap waits until the composer is idle and nothing is left to erase.
  assign swap_fire   = run && swap_pend_q && !bus.rd_en && !pend_valid_q;
  assign rd_word     = render_sel_q ? mem0[bus.rd_idx] : mem1[bus.rd_idx];

  // The last index read stays pending so repeated reads of it see the data.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_idx_d   = pend_idx_q;
    erase        = 1'b0;
    if (rd_hit) begin
      if (!pend_valid_q) begin
        pend_valid_d = 1'b1;
        pend_idx_d   = bus.rd_idx;
      end else if (pend_idx_q != bus.rd_idx) begin
        erase      = 1'b1;
        pend_idx_d = bus.rd_idx;
      end
    end else if (run && pend_valid_q) begin
      erase        = 1'b1;
      pend_valid_d = 1'b0;
    end
  end

  // Render buffer port takes renderer writes, display buffer port takes erases.
  always_comb begin
    we    = 2'b00;
    wa[0] = sweep_q;
    wa[1] = sweep_q;
    wd[0] = CLEAR_VALUE;
    wd[1] = CLEAR_VALUE;
    if (!run) begin
      we = 2'b11;
    end else begin
      if (bus.wr_en && wr_in_range) begin
        we[render_sel_q] = 1'b1;
        wa[render_sel_q] = bus.wr_idx;
        wd[render_sel_q] = bus.wr_data;
      end
      if (erase) begin
        we[!render_sel_q] = 1'b1;
        wa[!render_sel_q] = pend_idx_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (!run) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == LAST_IDX) state_d = ST_RUN;
    end
    ready_d      = run;
    render_sel_d = render_sel_q ^ swap_fire;
    swap_done_d  = swap_fire;
    swap_pend_d  = swap_pend_q;
    if (swap_fire) swap_pend_d = 1'b0;
    else if (run && bus.swap_req) swap_pend_d = 1'b1;
    rd_data_d = rd_data_q;
    if (bus.rd_en) rd_data_d = rd_hit ? rd_word : CLEAR_VALUE;
  end

  always_ff @(posedge clk) begin
    if (we[0]) mem0[wa[0]] <= wd[0];
    if (we[1]) mem1[wa[1]] <= wd[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      ready_q      <= 1'b0;
      render_sel_q <= 1'b0;
      swap_done_q  <= 1'b0;
      swap_pend_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_idx_q   <= '0;
      rd_data_q    <= CLEAR_VALUE;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      ready_q      <= ready_d;
      render_sel_q <= render_sel_d;
      swap_done_q  <= swap_done_d;
      swap_pend_q  <= swap_pend_d;
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= pend_idx_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign bus.ready      = ready_q;
  assign bus.render_sel = render_sel_q;
  assign bus.swap_done  = swap_done_q;
  assign bus.rd_data    = rd_data_q;

endmodule

// File: tb/tb_line_pingpong_buffer.sv
// Bench for line_pingpong_buffer: per-cycle vector table plus hand-written
// sequences; read data is checked against a scoreboard of expected pixels.
module tb_line_pingpong_buffer;
  localparam int DW = 8;
  localparam int LP = 640;
  localparam int IW = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  line_pingpong_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

  line_pingpong_buffer #(
    .DATA_WIDTH(DW), .LINE_PIXELS(LP), .IDX_WIDTH(IW), .CLEAR_VALUE(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] exp;
  } rd_exp_t;

  typedef struct {
    logic          wr_en;
    int            wr_idx;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    int            rd_idx;
    logic          swap_req;
    logic [DW-1:0] exp_rd;
    logic          exp_sd;
    logic          exp_rs;
  } vec_t;

  rd_exp_t sb_q[$];
  vec_t    vt[20];
  int      checks   = 0;
  int      failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.wr_en    = 1'b0;
    bus.wr_idx   = '0;
    bus.wr_data  = '0;
    bus.rd_en    = 1'b0;
    bus.rd_idx   = '0;
    bus.swap_req = 1'b0;
  endtask

  task automatic issue_read(input int idx, input logic [DW-1:0] exp);
    rd_exp_t e;
    bus.rd_en  = 1'b1;
    bus.rd_idx = IW'(idx);
    e.idx      = IW'(idx);
    e.exp      = exp;
    sb_q.push_back(e);
  endtask

  // One clock; a read issued before the edge is scored just after it.
  task automatic cycle();
    logic    issued;
    rd_exp_t e;
    issued = bus.rd_en;
    @(posedge clk);
    #1;
    if (issued) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard: read completed with no expectation queued");
      end else begin
        e = sb_q.pop_front();
        check($sformatf("rd_data idx %0d", e.idx), 32'(bus.rd_data), 32'(e.exp));
      end
    end
  endtask

  task automatic wait_ready(input int start, input string name);
    int n;
    n = start;
    while (!bus.ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(n), 32'(LP + 1));
  endtask

  task automatic read_all_clear(input string tag);
    for (int i = 0; i < LP; i++) begin
      issue_read(i, 8'h00);
      cycle();
    end
    idle();
    cycle();
    check({tag, " swap_done idle"}, 32'(bus.swap_done), 32'(0));
  endtask

  task automatic do_swap(input logic exp_rs);
    idle();
    bus.swap_req = 1'b1;
    cycle();
    bus.swap_req = 1'b0;
    check("swap_done after req edge", 32'(bus.swap_done), 32'(0));
    cycle();
    check("swap_done pulse", 32'(bus.swap_done), 32'(1));
    check("render_sel after swap", 32'(bus.render_sel), 32'(exp_rs));
    cycle();
    check("swap_done width", 32'(bus.swap_done), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle();
    rst_n = 1'b0;

    // render_sel starts 0: vectors 0-2 write and swap, 3-8 erase-behind,
    // 9-11 out of range, 12-19 write in the swap cycle then read it back.
    vt[0]  = '{1'b1,   3, 8'h5A, 1'b0,   0, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[1]  = '{1'b0,   0, 8'h00, 1'b0,   0, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[2]  = '{1'b0,   0, 8'h00, 1'b0,   0, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[3]  = '{1'b0,   0, 8'h00, 1'b1,   3, 1'b0, 8'h5A, 1'b0, 1'b1};
    vt[4]  = '{1'b0,   0, 8'h00, 1'b1,   3, 1'b0, 8'h5A, 1'b0, 1'b1};
    vt[5]  = '{1'b0,   0, 8'h00, 1'b1,   3, 1'b0, 8'h5A, 1'b0, 1'b1};
    vt[6]  = '{1'b0,   0, 8'h00, 1'b1,   4, 1'b0, 8'h00, 1'b0, 1'b1};
    vt[7]  = '{1'b0,   0, 8'h00, 1'b1,   3, 1'b0, 8'h00, 1'b0, 1'b1};
    vt[8]  = '{1'b0,   0, 8'h00, 1'b0,   0, 1'b0, 8'h00, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 700, 8'h77, 1'b1, 700, 1'b0, 8'h00, 1'b0, 1'b1};
    vt[10] = '{1'b1,   7, 8'h11, 1'b1,   7, 1'b0, 8'h00, 1'b0, 1'b1};
    vt[11] = '{1'b0,   0, 8'h00, 1'b0,   0, 1'b0, 8'h00, 1'b0, 1'b1};
    vt[12] = '{1'b0,   0, 8'h00, 1'b0,   0, 1'b1, 8'h00, 1'b0, 1'b1};
    vt[13] = '{1'b1,   9, 8'h33, 1'b0,   0, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[14] = '{1'b0,   0, 8'h00, 1'b1,   9, 1'b0, 8'h33, 1'b0, 1'b0};
    vt[15] = '{1'b0,   0, 8'h00, 1'b1,   7, 1'b0, 8'h11, 1'b0, 1'b0};
    vt[16] = '{1'b0,   0, 8'h00, 1'b1, 700, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[17] = '{1'b0,   0, 8'h00, 1'b1,   7, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[18] = '{1'b0,   0, 8'h00, 1'b1,   9, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[19] = '{1'b0,   0, 8'h00, 1'b0,   0, 1'b0, 8'h00, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 32'(bus.ready), 32'(0));
    check("reset render_sel", 32'(bus.render_sel), 32'(0));
    check("reset swap_done", 32'(bus.swap_done), 32'(0));
    check("reset rd_data", 32'(bus.rd_data), 32'(0));

    // Release reset with writes, swap requests and reads active during INIT.
    rst_n        = 1'b1;
    bus.wr_en    = 1'b1;
    bus.wr_idx   = IW'(5);
    bus.wr_data  = 8'hFF;
    bus.swap_req = 1'b1;
    bus.rd_en    = 1'b1;
    bus.rd_idx   = IW'(5);
    n = 0;
    repeat (600) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("init rd_data", 32'(bus.rd_data), 32'(0));
    check("init ready low", 32'(bus.ready), 32'(0));
    idle();
    wait_ready(n, "ready latency after reset");
    check("render_sel after init", 32'(bus.render_sel), 32'(0));
    check("swap_done after init", 32'(bus.swap_done), 32'(0));
    check("rd_data after init", 32'(bus.rd_data), 32'(0));

    read_all_clear("buf1");
    do_swap(1'b1);
    read_all_clear("buf0");
    do_swap(1'b0);

    for (int i = 0; i < 20; i++) begin
      bus.wr_en    = vt[i].wr_en;
      bus.wr_idx   = IW'(vt[i].wr_idx);
      bus.wr_data  = vt[i].wr_data;
      bus.swap_req = vt[i].swap_req;
      bus.rd_en    = 1'b0;
      if (vt[i].rd_en) issue_read(vt[i].rd_idx, vt[i].exp_rd);
      cycle();
      check($sformatf("vec%0d swap_done", i), 32'(bus.swap_done), 32'(vt[i].exp_sd));
      check($sformatf("vec%0d render_sel", i), 32'(bus.render_sel), 32'(vt[i].exp_rs));
    end
    idle();

    // Swap requested twice while the composer is mid-line.
    for (int i = 0; i < 7; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_idx  = IW'(20 + i);
      bus.wr_data = DW'(8'h80 + i);
      cycle();
    end
    idle();
    for (int i = 0; i < 11; i++) begin
      issue_read(10 + i, 8'h00);
      bus.swap_req = (i == 2 || i == 6);
      cycle();
      check($sformatf("busy%0d swap_done", i), 32'(bus.swap_done), 32'(0));
      check($sformatf("busy%0d render_sel", i), 32'(bus.render_sel), 32'(0));
    end
    idle();
    cycle();
    check("swap held for erase flush", 32'(bus.swap_done), 32'(0));
    cycle();
    check("deferred swap_done", 32'(bus.swap_done), 32'(1));
    check("deferred render_sel", 32'(bus.render_sel), 32'(1));
    cycle();
    check("merged swap no repeat a", 32'(bus.swap_done), 32'(0));
    cycle();
    check("merged swap no repeat b", 32'(bus.swap_done), 32'(0));
    check("merged swap render_sel", 32'(bus.render_sel), 32'(1));
    for (int i = 0; i < 6; i++) begin
      issue_read(20 + i, DW'(8'h80 + i));
      cycle();
    end
    idle();
    cycle();
    check("rd_data hold while idle", 32'(bus.rd_data), 32'(8'h85));
    issue_read(20, 8'h00);
    cycle();
    idle();
    cycle();

    // Reset mid-line with an erase and a swap pending.
    issue_read(26, 8'h86);
    cycle();
    issue_read(26, 8'h86);
    bus.swap_req = 1'b1;
    bus.wr_en    = 1'b1;
    bus.wr_idx   = IW'(30);
    bus.wr_data  = 8'hC3;
    cycle();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset ready", 32'(bus.ready), 32'(0));
    check("async reset render_sel", 32'(bus.render_sel), 32'(0));
    check("async reset swap_done", 32'(bus.swap_done), 32'(0));
    check("async reset rd_data", 32'(bus.rd_data), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready(0, "ready latency after mid-line reset");
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("post-reset%0d swap_done", i), 32'(bus.swap_done), 32'(0));
      check($sformatf("post-reset%0d render_sel", i), 32'(bus.render_sel), 32'(0));
    end
    issue_read(30, 8'h00);
    cycle();
    issue_read(26, 8'h00);
    cycle();
    idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
